dds_sine_gen: RTL and testbench
===============================

Name: dds_sine_gen

Overview:
Parametrised direct-digital-synthesis sine/cosine generator; successor to the combinational 32-entry quarter-wave sine table.
- Phase accumulator with programmable increment drives a quarter-wave ROM.
- Quadrant folding reconstructs full-wave signed sine and cosine samples.
- Registered two-stage pipeline with a valid strobe; feeds DAC/test-tone and modulator paths.

Parameters:
PHASE_W, 16, phase accumulator and increment width (must be >= ADDR_W+2)
ADDR_W, 5, quarter-wave table address width; table depth 2^ADDR_W
DATA_W, 8, signed output sample width; table magnitude max 2^(DATA_W-1)-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  advance accumulator and launch one sample this cycle
clr  input  1  synchronous phase clear
inc_we  input  1  load inc_in into increment register
inc_in  input  PHASE_W  phase increment (frequency word), unsigned
sin_out  output  DATA_W  signed sine sample, two's complement
cos_out  output  DATA_W  signed cosine sample, two's complement
valid_out  output  1  sin_out/cos_out hold a new sample this cycle

Behaviour:
- Reset (async, rst=1): phase=0, inc=0, both pipeline valid bits=0, sin_out=0, cos_out=0, valid_out=0. Reset mid-operation discards all in-flight samples immediately.
- Table: T[i] = round((2^(DATA_W-1)-1) * sin((i+0.5)*pi/2^(ADDR_W+1))), i=0..2^ADDR_W-1. Half-sample offset, so no zero entry and the folding is exact.
  - Defaults: 3,9,16,22,28,34,40,46,51,57,63,68,73,78,83,88,92,96,100,104,107,111,113,116,118,121,122,124,125,126,127,127.
- Phase decode: q = phase[PHASE_W-1 -: 2], a = phase[PHASE_W-3 -: ADDR_W]; lower bits are truncated, with no rounding or dithering.
- Sine fold:
  - q=0 -> +T[a]
  - q=1 -> +T[N-1-a]
  - q=2 -> -T[a]
  - q=3 -> -T[N-1-a]
  - N = 2^ADDR_W.
- Cosine: same fold using quadrant (q+1) mod 4 and the same a.
- Pipeline, for a cycle n with en=1:
  - Stage 0 samples the current phase register value P.
  - Stage 1 (edge n) registers q, a and valid.
  - Stage 2 (edge n+1) registers the folded sin/cos and valid_out.
  - Outputs for P are visible in cycle n+2; fixed latency 2, full throughput.
- Accumulator: on each edge with en=1 and clr=0, phase <= (phase + inc) mod 2^PHASE_W. Wrap-around is silent.
- en=0: phase holds. valid_out drops 2 cycles later. sin_out/cos_out hold their last values (not zeroed).
- clr=1: phase <= 0 regardless of en; clr has priority over the accumulate. If en=1 in the same cycle, a sample from the pre-clear phase is still launched. In-flight samples complete normally.
- inc_we=1: inc <= inc_in at the edge. An accumulate in the same cycle uses the old inc; the new value applies from the next cycle.
- Output arithmetic: negation of T is exact; T max is 2^(DATA_W-1)-1, so there is no overflow and no -2^(DATA_W-1) code.
- All outputs come directly from registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package (dsp_pkg): quadrant encoding constants Q0..Q3; the fold function (quadrant, index -> signed sample); the table formula constant function.
- One sub-module: quarter_sine_rom.
  - Parametrised by ADDR_W and DATA_W.
  - Two read ports: one for the sine index, one for the cosine index.
  - Registered read, which forms stage 2.
  - Default contents equal the table listed above.

Test Plan:
- Reset release, inc_we=1 inc_in=0x0200, then en=1 continuously -> first valid_out 3 cycles after the inc load (1 cycle for inc to take effect, then latency 2). First samples sin=3,9,16,22,...; cos=127,127,126,... Period is 128 samples; samples 64..127 are the negated mirror (sin: -3,-9,...).
- inc=0x8000 -> phase alternates 0x0000/0x8000; sin_out alternates 3,-3; cos_out alternates 127,-127.
- Mid-run, change inc from 0x0200 to 0x0400 with en=1 in the same cycle -> one more step of 0x0200, then steps of 0x0400 (sin sequence skips every other table entry).
- Pulse clr while en=1 at phase 0x3000 -> that cycle's sample uses 0x3000 (sin=T[24]=118). Next sample uses phase 0 (sin=3, cos=127).
- en deasserted for 5 cycles -> valid_out low 2 cycles after, outputs hold; on re-assert, the sequence resumes from the held phase.
- Assert rst mid-stream -> outputs and valid_out go to 0 asynchronously; after release phase=0 and inc=0, so en=1 gives constant sin=3, cos=127.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DDS helpers: quadrant codes, quadrant fold and quarter-wave table formula.
// Pure constants/functions; no latency or flow control.
package dsp_pkg;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int DEF_TAB [32] = '{
    3, 9, 16, 22, 28, 34, 40, 46, 51, 57, 63, 68, 73, 78, 83, 88,
    92, 96, 100, 104, 107, 111, 113, 116, 118, 121, 122, 124, 125, 126, 127, 127
  };

  // Odd quadrants walk the quarter table backwards.
  function automatic logic fold_mirror(logic [1:0] q);
    case (q)
      Q1, Q3:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int fold_sample(logic [1:0] q, int t_val);
    case (q)
      Q0, Q1:  return t_val;
      Q2, Q3:  return -t_val;
      default: return t_val;
    endcase
  endfunction

  // round(amp * sin((i+0.5)*pi/2^(addr_w+1))); series is accurate well past 16-bit samples.
  function automatic int sine_tab(int idx, int addr_w, int data_w);
    real amp;
    real x;
    real term;
    real s;
    if (addr_w == 5 && data_w == 8) return DEF_TAB[idx[4:0]];
    amp  = real'((1 << (data_w - 1)) - 1);
    x    = (real'(idx) + 0.5) * 3.14159265358979 / real'(1 << (addr_w + 1));
    term = x;
    s    = x;
    for (int k = 1; k < 8; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    return $rtoi(s * amp + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Dual-port quarter-wave sine ROM with fold; registered read is pipeline stage 2.
// Latency 1; updates only when i_rd_en, otherwise holds last samples (no backpressure).
module quarter_sine_rom
  import dsp_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [1:0]        i_sin_q,
  input  logic [ADDR_W-1:0] i_sin_a,
  input  logic [1:0]        i_cos_q,
  input  logic [ADDR_W-1:0] i_cos_a,
  output logic [DATA_W-1:0] o_sin,
  output logic [DATA_W-1:0] o_cos
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] w_tab [N];
  logic [ADDR_W-1:0] w_sin_idx;
  logic [ADDR_W-1:0] w_cos_idx;
  logic [DATA_W-1:0] w_sin;
  logic [DATA_W-1:0] w_cos;
  logic [DATA_W-1:0] r_sin;
  logic [DATA_W-1:0] r_cos;

  for (genvar g = 0; g < N; g++) begin : g_tab
    assign w_tab[g] = DATA_W'(sine_tab(g, ADDR_W, DATA_W));
  end

  // N-1-a is the bitwise inverse of a within ADDR_W bits.
  assign w_sin_idx = fold_mirror(i_sin_q) ? ~i_sin_a : i_sin_a;
  assign w_cos_idx = fold_mirror(i_cos_q) ? ~i_cos_a : i_cos_a;
  assign w_sin     = DATA_W'(fold_sample(i_sin_q, int'(w_tab[w_sin_idx])));
  assign w_cos     = DATA_W'(fold_sample(i_cos_q, int'(w_tab[w_cos_idx])));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sin <= '0;
      r_cos <= '0;
    end else if (i_rd_en) begin
      r_sin <= w_sin;
      r_cos <= w_cos;
    end
  end

  assign o_sin = r_sin;
  assign o_cos = r_cos;

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine/cosine generator: phase accumulator, quadrant decode, folded quarter-wave ROM.
// Fixed latency 2 from en, full throughput; free-running, no backpressure.
module dds_sine_gen
  import dsp_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               inc_we,
  input  logic [PHASE_W-1:0] inc_in,
  output logic [DATA_W-1:0]  sin_out,
  output logic [DATA_W-1:0]  cos_out,
  output logic               valid_out
);

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_inc;
  logic [1:0]         r_q;
  logic [ADDR_W-1:0]  r_a;
  logic               r_vld1;
  logic               r_vld2;
  logic [1:0]         w_cos_q;

  // clr wins over accumulate, but an en in the same cycle still samples the old phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_inc   <= '0;
      r_q     <= '0;
      r_a     <= '0;
      r_vld1  <= 1'b0;
      r_vld2  <= 1'b0;
    end else begin
      if (inc_we) r_inc <= inc_in;
      if (clr) r_phase <= '0;
      else if (en) r_phase <= r_phase + r_inc;
      if (en) begin
        r_q <= r_phase[PHASE_W-1 -: 2];
        r_a <= r_phase[PHASE_W-3 -: ADDR_W];
      end
      r_vld1 <= en;
      r_vld2 <= r_vld1;
    end
  end

  assign w_cos_q = r_q + Q1;

  quarter_sine_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .clk     (clk),
    .rst     (rst),
    .i_rd_en (r_vld1),
    .i_sin_q (r_q),
    .i_sin_a (r_a),
    .i_cos_q (w_cos_q),
    .i_cos_a (r_a),
    .o_sin   (sin_out),
    .o_cos   (cos_out)
  );

  assign valid_out = r_vld2;

endmodule

// File: tb/tb_dds_sine_gen.sv
module tb_dds_sine_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        inc_we = 1'b0;
  logic [15:0] inc_in = 16'h0000;
  logic [7:0]  sin_out;
  logic [7:0]  cos_out;
  logic        valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  int T [32] = '{3, 9, 16, 22, 28, 34, 40, 46, 51, 57, 63, 68, 73, 78, 83, 88,
                 92, 96, 100, 104, 107, 111, 113, 116, 118, 121, 122, 124, 125, 126, 127, 127};

  // Reference model state
  logic [15:0] m_phase;
  logic [15:0] m_inc;
  logic [15:0] e_ph1;
  logic [15:0] e_ph2;
  logic        e_vld1;
  logic        e_vld2;
  logic        e_have;

  dds_sine_gen #(.PHASE_W(16), .ADDR_W(5), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .inc_we    (inc_we),
    .inc_in    (inc_in),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  function automatic int exp_s(logic [15:0] p, bit is_cos);
    logic [1:0] q;
    int         a;
    int         v;
    q = p[15:14] + (is_cos ? 2'd1 : 2'd0);
    a = int'(p[13:9]);
    v = q[0] ? T[31 - a] : T[a];
    return q[1] ? -v : v;
  endfunction

  function automatic logic [7:0] e_sin();
    return e_have ? 8'(exp_s(e_ph2, 1'b0)) : 8'h00;
  endfunction

  function automatic logic [7:0] e_cos();
    return e_have ? 8'(exp_s(e_ph2, 1'b1)) : 8'h00;
  endfunction

  task automatic model_reset();
    m_phase = '0; m_inc = '0; e_ph1 = '0; e_ph2 = '0;
    e_vld1 = 1'b0; e_vld2 = 1'b0; e_have = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    e_vld2 = e_vld1;
    if (e_vld1) begin e_ph2 = e_ph1; e_have = 1'b1; end
    e_vld1 = en;
    if (en) e_ph1 = m_phase;
    if (clr) m_phase = '0;
    else if (en) m_phase = m_phase + m_inc;
    if (inc_we) m_inc = inc_in;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; inc_we = 1'b0;
    model_reset();
    #1;
    n_tests++; if (sin_out !== 8'h00) begin n_fail++; $display("FAIL reset_sin got %0d want 0", $signed(sin_out)); end
    n_tests++; if (cos_out !== 8'h00) begin n_fail++; $display("FAIL reset_cos got %0d want 0", $signed(cos_out)); end
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    inc_we = 1'b1; inc_in = 16'h0200;
    tick();
    inc_we = 1'b0; en = 1'b1;
    tick();
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL sweep_first_valid got %b want 0", valid_out); end
    for (int k = 0; k < 128; k++) begin
      tick();
      n_tests++;
      if (valid_out !== 1'b1 || sin_out !== 8'(exp_s(16'(k * 512), 1'b0)) || cos_out !== 8'(exp_s(16'(k * 512), 1'b1))) begin
        n_fail++;
        $display("FAIL sweep k=%0d got v=%b s=%0d c=%0d want v=1 s=%0d c=%0d", k, valid_out,
                 $signed(sin_out), $signed(cos_out), exp_s(16'(k * 512), 1'b0), exp_s(16'(k * 512), 1'b1));
      end
      if (k == 0 || k == 1 || k == 64) begin
        n_tests++;
        if (sin_out !== 8'(k == 0 ? 3 : (k == 1 ? 9 : -3)) || cos_out !== 8'(k == 64 ? -127 : 127)) begin
          n_fail++;
          $display("FAIL sweep_literal k=%0d got s=%0d c=%0d", k, $signed(sin_out), $signed(cos_out));
        end
      end
    end
  endtask

  task automatic test_half_rate();
    en = 1'b0; clr = 1'b1; inc_we = 1'b1; inc_in = 16'h8000;
    tick();
    clr = 1'b0; inc_we = 1'b0; en = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      tick();
      n_tests++;
      if (valid_out !== 1'b1 || sin_out !== 8'(j % 2 == 1 ? -3 : 3) || cos_out !== 8'(j % 2 == 1 ? -127 : 127)) begin
        n_fail++;
        $display("FAIL half_rate j=%0d got v=%b s=%0d c=%0d want s=%0d c=%0d", j, valid_out,
                 $signed(sin_out), $signed(cos_out), (j % 2 == 1 ? -3 : 3), (j % 2 == 1 ? -127 : 127));
      end
    end
  endtask

  task automatic test_inc_change();
    int got [$];
    int want [10] = '{3, 9, 16, 22, 28, 34, 46, 57, 68, 78};
    en = 1'b0; clr = 1'b1; inc_we = 1'b1; inc_in = 16'h0200;
    tick();
    clr = 1'b0; inc_we = 1'b0; en = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (t == 4) begin inc_we = 1'b1; inc_in = 16'h0400; end
      tick();
      inc_we = 1'b0;
      if (valid_out === 1'b1) got.push_back(int'($signed(sin_out)));
      n_tests++;
      if (valid_out !== e_vld2 || sin_out !== e_sin() || cos_out !== e_cos()) begin
        n_fail++;
        $display("FAIL inc_change_model t=%0d got v=%b s=%0d c=%0d want v=%b s=%0d c=%0d", t, valid_out,
                 $signed(sin_out), $signed(cos_out), e_vld2, $signed(e_sin()), $signed(e_cos()));
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (got.size() <= i) begin
        n_fail++; $display("FAIL inc_change_seq i=%0d got no sample want %0d", i, want[i]);
      end else if (got[i] != want[i]) begin
        n_fail++; $display("FAIL inc_change_seq i=%0d got %0d want %0d", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_clr();
    en = 1'b0; clr = 1'b1; inc_we = 1'b1; inc_in = 16'h0200;
    tick();
    clr = 1'b0; inc_we = 1'b0; en = 1'b1;
    for (int t = 0; t < 24; t++) begin
      tick();
      n_tests++;
      if (valid_out !== e_vld2 || sin_out !== e_sin() || cos_out !== e_cos()) begin
        n_fail++;
        $display("FAIL clr_ramp t=%0d got s=%0d c=%0d want s=%0d c=%0d", t,
                 $signed(sin_out), $signed(cos_out), $signed(e_sin()), $signed(e_cos()));
      end
    end
    n_tests++; if (m_phase !== 16'h3000) begin n_fail++; $display("FAIL clr_setup model phase %h want 3000", m_phase); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    n_tests++;
    if (sin_out !== 8'd118 || cos_out !== 8'd46 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL clr_presample got v=%b s=%0d c=%0d want v=1 s=118 c=46", valid_out, $signed(sin_out), $signed(cos_out));
    end
    tick();
    n_tests++;
    if (sin_out !== 8'd3 || cos_out !== 8'd127 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL clr_postsample got v=%b s=%0d c=%0d want v=1 s=3 c=127", valid_out, $signed(sin_out), $signed(cos_out));
    end
  endtask

  task automatic test_hold();
    en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_tests++;
      if (valid_out !== (t == 0) || sin_out !== 8'd9 || cos_out !== 8'd127) begin
        n_fail++;
        $display("FAIL hold t=%0d got v=%b s=%0d c=%0d want v=%b s=9 c=127", t, valid_out,
                 $signed(sin_out), $signed(cos_out), (t == 0));
      end
    end
    en = 1'b1;
    tick();
    n_tests++;
    if (valid_out !== 1'b0 || sin_out !== 8'd9) begin
      n_fail++; $display("FAIL hold_resume0 got v=%b s=%0d want v=0 s=9", valid_out, $signed(sin_out));
    end
    tick();
    n_tests++;
    if (valid_out !== 1'b1 || sin_out !== 8'd16 || cos_out !== 8'd126) begin
      n_fail++; $display("FAIL hold_resume1 got v=%b s=%0d c=%0d want v=1 s=16 c=126", valid_out, $signed(sin_out), $signed(cos_out));
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (sin_out !== 8'h00 || cos_out !== 8'h00 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got v=%b s=%0d c=%0d want all 0", valid_out, $signed(sin_out), $signed(cos_out));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    en = 1'b1;
    tick();
    tick();
    for (int t = 0; t < 4; t++) begin
      tick();
      n_tests++;
      if (valid_out !== 1'b1 || sin_out !== 8'd3 || cos_out !== 8'd127) begin
        n_fail++;
        $display("FAIL post_reset t=%0d got v=%b s=%0d c=%0d want v=1 s=3 c=127", t, valid_out,
                 $signed(sin_out), $signed(cos_out));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_half_rate();
    test_inc_change();
    test_clr();
    test_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
